key_filter_multi: RTL and testbench
===================================

# key_filter_multi

Multi-channel debouncer for active-low mechanical keys. Each channel synchronises its raw input and commits a new debounced level once the input has been stable for CNT_MAX+1 clocks. On each commit it emits a one-cycle press or release pulse. An optional long-press pulse can be compiled in. The block sits between the board key pins and the control logic (LED, beeper and menu FSMs), so those consumers no longer each need their own debouncer.

## Interface
- KEY_NUM, 4: number of independent key channels (≥1).
- CNT_MAX, 20'd999_999: debounce window minus one, in clocks (20 ms at 50 MHz).
- LONG_MAX, 26'd49_999_999: long-press threshold minus one, in clocks (1 s at 50 MHz). Used only with KEY_FILTER_LONG_EN.

Ports:
- sys_clk  in  1  system clock; all state is on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- key_in  in  KEY_NUM  raw key pins, asynchronous, 0 = pressed.
- key_level  out  KEY_NUM  debounced level per channel, 0 = pressed.
- press_flag  out  KEY_NUM  one-cycle pulse when a channel commits to 0.
- release_flag  out  KEY_NUM  one-cycle pulse when a channel commits to 1.
- long_flag  out  KEY_NUM  one-cycle pulse when a held key reaches the long-press threshold.

## Operation
- Synchroniser: two-flop synchroniser per channel. Both flops reset to 1. key_sync is the second flop.
- Debounce state per channel: key_level register (reset 1) and counter cnt of width $clog2(CNT_MAX+1) (reset 0).
- Each edge, if key_sync == key_level: cnt <= 0. Any bounce back to the committed level restarts the window.
- Each edge, if key_sync != key_level and cnt != CNT_MAX: cnt <= cnt+1.
- Each edge, if key_sync != key_level and cnt == CNT_MAX (commit):
  - key_level <= key_sync and cnt <= 0.
  - press_flag[i] <= 1 if key_sync == 0; otherwise release_flag[i] <= 1.
- All flag outputs are registered and are 0 on every edge with no event. No flag is ever high for more than one cycle.
- Long press (macro on), per channel:
  - State: counter lcnt of width $clog2(LONG_MAX+1) and a fired bit, both reset 0.
  - On the press-commit edge: lcnt <= 0, fired <= 0.
  - On later edges with key_level == 0 and fired == 0: if lcnt == LONG_MAX, long_flag[i] <= 1 and fired <= 1; else lcnt+1.
  - fired holds until the release commit, which clears lcnt and fired. There is one long_flag per press and no auto-repeat.
  - If a release commit lands on the same edge as lcnt == LONG_MAX, the release wins and no long_flag is emitted.
- Channels are fully independent. Several channels may pulse on the same edge.
- Reset asserted mid-debounce or mid-hold clears everything immediately. After reset release, no flag fires for a key already held until a full debounce window elapses.

## Timing
- Reset values: key_level = all 1; press_flag, release_flag, long_flag = all 0.
- Latency: edges are numbered from 1, where edge 1 is the first edge sampling the new key_in level. The commit and flag assertion occur on edge CNT_MAX+3. The flag is high for exactly one cycle after that edge.
- A change of key_in shorter than CNT_MAX+1 synchronised clocks produces no flag and leaves key_level unchanged.
- long_flag asserts on edge P+LONG_MAX+1, where P is the press-commit edge.
- key_level changes on the same edge as the corresponding press_flag or release_flag.

## Configuration
- KEY_FILTER_LONG_EN defined: lcnt and fired logic is present, and long_flag behaves as described in Operation.
- KEY_FILTER_LONG_EN undefined: no long-press logic is synthesised, long_flag is tied to 0 and LONG_MAX is ignored. All other behaviour is identical.

## Test plan
All scenarios use KEY_NUM=4, CNT_MAX=9, LONG_MAX=49, macro defined unless noted.
- Clean press on key_in[0], held 30 clocks: press_flag[0] is high for one cycle after edge 12, and key_level[0] drops on the same edge. No flags on any other channel.
- Bounce: key_in[1] low 6 clocks, high 2, then low steady. No flag during the bounce; press_flag[1] fires 12 edges after the final falling edge.
- Long hold on key_in[2] for 80 clocks after press commit: long_flag[2] fires once, 50 edges after press_flag[2]. Release then gives release_flag[2] and no second long_flag.
- Simultaneous: key_in[3] and key_in[0] fall on the same edge. press_flag is 4'b1001 in a single cycle.
- Reset mid-window: key_in[0] low for 8 clocks, then sys_rst_n pulsed low. All outputs return to reset values and press_flag[0] fires 12 edges after reset release.
- Macro undefined, 80-clock hold: long_flag stays 0 throughout, and press and release timing is unchanged.

Source files
------------

// File: rtl/key_filter_multi_if.sv
// Key filter bus: raw key pins in, debounced levels and event pulses out.
interface key_filter_multi_if #(
    parameter int KEY_NUM = 4
);
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_level;
    logic [KEY_NUM-1:0] press_flag;
    logic [KEY_NUM-1:0] release_flag;
    logic [KEY_NUM-1:0] long_flag;

    modport master (
        output key_in,
        input  key_level,
        input  press_flag,
        input  release_flag,
        input  long_flag
    );

    modport slave (
        input  key_in,
        output key_level,
        output press_flag,
        output release_flag,
        output long_flag
    );
endinterface

// File: rtl/key_filter_multi.sv
// Multi-channel debouncer for active-low keys with press/release pulses.
// Long-press pulse is compiled in only when KEY_FILTER_LONG_EN is defined.
module key_filter_multi #(
    parameter int          KEY_NUM  = 4,
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
    input logic               sys_clk,
    input logic               sys_rst_n,
    key_filter_multi_if.slave bus
);
    localparam int CNT_W = (CNT_MAX == 20'd0) ? 1 : $clog2(32'(CNT_MAX) + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

`ifdef KEY_FILTER_LONG_EN
    localparam int LONG_W = (LONG_MAX == 26'd0) ? 1 : $clog2(32'(LONG_MAX) + 1);
    localparam logic [LONG_W-1:0] LONG_TOP = LONG_W'(LONG_MAX);
`else
    logic unused_long;
    assign unused_long = ^LONG_MAX;
`endif

    logic [KEY_NUM-1:0] sync_q1;
    logic [KEY_NUM-1:0] key_sync;

    // Both flops reset to released so a held key after reset needs a full window.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1  <= '1;
            key_sync <= '1;
        end else begin
            sync_q1  <= bus.key_in;
            key_sync <= sync_q1;
        end
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             level;
        logic             press_q;
        logic             rel_q;
        logic             commit;

        assign commit = (key_sync[i] != level) && (cnt == CNT_TOP);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cnt     <= '0;
                level   <= 1'b1;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                if (key_sync[i] == level) begin
                    cnt <= '0;
                end else if (!commit) begin
                    cnt <= cnt + CNT_W'(1);
                end else begin
                    level   <= key_sync[i];
                    cnt     <= '0;
                    press_q <= ~key_sync[i];
                    rel_q   <= key_sync[i];
                end
            end
        end

        assign bus.key_level[i]    = level;
        assign bus.press_flag[i]   = press_q;
        assign bus.release_flag[i] = rel_q;

`ifdef KEY_FILTER_LONG_EN
        logic [LONG_W-1:0] lcnt;
        logic              fired;
        logic              long_q;

        // Any commit restarts the hold timer; a release commit beats a same-edge threshold hit.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                lcnt   <= '0;
                fired  <= 1'b0;
                long_q <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (commit) begin
                    lcnt  <= '0;
                    fired <= 1'b0;
                end else if (!level && !fired) begin
                    if (lcnt == LONG_TOP) begin
                        long_q <= 1'b1;
                        fired  <= 1'b1;
                    end else begin
                        lcnt <= lcnt + LONG_W'(1);
                    end
                end
            end
        end

        assign bus.long_flag[i] = long_q;
`else
        assign bus.long_flag[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_key_filter_multi.sv
// Scoreboard bench for key_filter_multi (KEY_NUM=4, CNT_MAX=9, LONG_MAX=49).
// Long-press expectations follow whether KEY_FILTER_LONG_EN is defined.
module tb_key_filter_multi;
    localparam int WIN = 12;
    localparam int LONG_OFS = 50;
`ifdef KEY_FILTER_LONG_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    typedef struct {
        int         at;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } exp_t;

    logic sys_clk;
    logic sys_rst_n;
    int   cyc;
    int   compared;
    int   failed;
    exp_t sb[$];
    exp_t e;
    logic [3:0] exp_lvl;
    logic [3:0] exp_p;
    logic [3:0] exp_r;
    logic [3:0] exp_l;

    key_filter_multi_if #(.KEY_NUM(4)) bus ();

    key_filter_multi #(
        .KEY_NUM (4),
        .CNT_MAX (20'd9),
        .LONG_MAX(26'd49)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one edge, sample 1 time unit later, and retire due scoreboard entries.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
        exp_p = '0;
        exp_r = '0;
        exp_l = '0;
        if (!sys_rst_n) begin
            sb.delete();
            exp_lvl = '1;
        end
        while (sb.size() != 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            exp_p |= e.press;
            exp_r |= e.rel;
            exp_l |= e.lng;
            exp_lvl = (exp_lvl & ~e.press) | e.rel;
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        bus.key_in = 4'hF;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) sys_rst_n = 1'b1;
            tick();
            compared++;
            if ({bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                failed++;
                $display("[TB] FAIL reset cyc=%0d got lvl=%b p=%b r=%b l=%b want lvl=%b p=%b r=%b l=%b",
                         cyc, bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag, exp_lvl, exp_p, exp_r, exp_l);
            end
        end
    endtask

    task automatic test_clean_press();
        for (int k = 0; k < 50; k++) begin
            if (k == 0) begin bus.key_in[0] = 1'b0; sb.push_back('{cyc + WIN, 4'b0001, 4'b0000, 4'b0000}); end
            if (k == 30) begin bus.key_in[0] = 1'b1; sb.push_back('{cyc + WIN, 4'b0000, 4'b0001, 4'b0000}); end
            tick();
            compared++;
            if ({bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                failed++;
                $display("[TB] FAIL clean_press cyc=%0d got lvl=%b p=%b r=%b l=%b want lvl=%b p=%b r=%b l=%b",
                         cyc, bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag, exp_lvl, exp_p, exp_r, exp_l);
            end
        end
        compared++;
        if (sb.size() != 0) begin failed++; $display("[TB] FAIL clean_press_pending got %0d want 0", sb.size()); end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 45; k++) begin
            if (k == 0) bus.key_in[1] = 1'b0;
            if (k == 6) bus.key_in[1] = 1'b1;
            if (k == 8) begin bus.key_in[1] = 1'b0; sb.push_back('{cyc + WIN, 4'b0010, 4'b0000, 4'b0000}); end
            if (k == 28) begin bus.key_in[1] = 1'b1; sb.push_back('{cyc + WIN, 4'b0000, 4'b0010, 4'b0000}); end
            tick();
            compared++;
            if ({bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                failed++;
                $display("[TB] FAIL bounce cyc=%0d got lvl=%b p=%b r=%b l=%b want lvl=%b p=%b r=%b l=%b",
                         cyc, bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag, exp_lvl, exp_p, exp_r, exp_l);
            end
        end
        compared++;
        if (sb.size() != 0) begin failed++; $display("[TB] FAIL bounce_pending got %0d want 0", sb.size()); end
    endtask

    // 9 low clocks is one short of the window; 10 low clocks is exactly the window.
    task automatic test_window_boundary();
        for (int k = 0; k < 55; k++) begin
            if (k == 0) bus.key_in[0] = 1'b0;
            if (k == 9) bus.key_in[0] = 1'b1;
            if (k == 25) begin bus.key_in[0] = 1'b0; sb.push_back('{cyc + WIN, 4'b0001, 4'b0000, 4'b0000}); end
            if (k == 35) begin bus.key_in[0] = 1'b1; sb.push_back('{cyc + WIN, 4'b0000, 4'b0001, 4'b0000}); end
            tick();
            compared++;
            if ({bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                failed++;
                $display("[TB] FAIL window_boundary cyc=%0d got lvl=%b p=%b r=%b l=%b want lvl=%b p=%b r=%b l=%b",
                         cyc, bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag, exp_lvl, exp_p, exp_r, exp_l);
            end
        end
        compared++;
        if (sb.size() != 0) begin failed++; $display("[TB] FAIL window_boundary_pending got %0d want 0", sb.size()); end
    endtask

    task automatic test_long_hold();
        for (int k = 0; k < 110; k++) begin
            if (k == 0) begin
                bus.key_in[2] = 1'b0;
                sb.push_back('{cyc + WIN, 4'b0100, 4'b0000, 4'b0000});
                if (LONG_EN) sb.push_back('{cyc + WIN + LONG_OFS, 4'b0000, 4'b0000, 4'b0100});
            end
            if (k == WIN + 80) begin bus.key_in[2] = 1'b1; sb.push_back('{cyc + WIN, 4'b0000, 4'b0100, 4'b0000}); end
            tick();
            compared++;
            if ({bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                failed++;
                $display("[TB] FAIL long_hold cyc=%0d got lvl=%b p=%b r=%b l=%b want lvl=%b p=%b r=%b l=%b",
                         cyc, bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag, exp_lvl, exp_p, exp_r, exp_l);
            end
        end
        compared++;
        if (sb.size() != 0) begin failed++; $display("[TB] FAIL long_hold_pending got %0d want 0", sb.size()); end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 40; k++) begin
            if (k == 0) begin
                bus.key_in[0] = 1'b0;
                bus.key_in[3] = 1'b0;
                sb.push_back('{cyc + WIN, 4'b1001, 4'b0000, 4'b0000});
            end
            if (k == 20) begin
                bus.key_in[0] = 1'b1;
                bus.key_in[3] = 1'b1;
                sb.push_back('{cyc + WIN, 4'b0000, 4'b1001, 4'b0000});
            end
            tick();
            compared++;
            if ({bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                failed++;
                $display("[TB] FAIL simultaneous cyc=%0d got lvl=%b p=%b r=%b l=%b want lvl=%b p=%b r=%b l=%b",
                         cyc, bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag, exp_lvl, exp_p, exp_r, exp_l);
            end
        end
        compared++;
        if (sb.size() != 0) begin failed++; $display("[TB] FAIL simultaneous_pending got %0d want 0", sb.size()); end
    endtask

    task automatic test_reset_mid_window();
        for (int k = 0; k < 50; k++) begin
            if (k == 0) bus.key_in[0] = 1'b0;
            if (k == 8) sys_rst_n = 1'b0;
            if (k == 10) begin sys_rst_n = 1'b1; sb.push_back('{cyc + WIN, 4'b0001, 4'b0000, 4'b0000}); end
            if (k == 30) begin bus.key_in[0] = 1'b1; sb.push_back('{cyc + WIN, 4'b0000, 4'b0001, 4'b0000}); end
            tick();
            compared++;
            if ({bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag} !== {exp_lvl, exp_p, exp_r, exp_l}) begin
                failed++;
                $display("[TB] FAIL reset_mid_window cyc=%0d got lvl=%b p=%b r=%b l=%b want lvl=%b p=%b r=%b l=%b",
                         cyc, bus.key_level, bus.press_flag, bus.release_flag, bus.long_flag, exp_lvl, exp_p, exp_r, exp_l);
            end
        end
        compared++;
        if (sb.size() != 0) begin failed++; $display("[TB] FAIL reset_mid_window_pending got %0d want 0", sb.size()); end
    endtask

    initial begin
        cyc      = 0;
        compared = 0;
        failed   = 0;
        exp_lvl  = 4'hF;
        exp_p    = '0;
        exp_r    = '0;
        exp_l    = '0;
        $display("[TB] starting, long-press enabled = %0d", LONG_EN);
        test_reset();
        test_clean_press();
        test_bounce();
        test_window_boundary();
        test_long_hold();
        test_simultaneous();
        test_reset_mid_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
